// File: rtl/game_countdown_timer_if.sv
// Round-control and display bundle between the game FSM, the countdown
// timer and the display/LED drivers.
interface game_countdown_timer_if;
    logic       game_active;
    logic       timer_expired;
    logic [6:0] time_left;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       time_warning;

    modport master (
        output game_active,
        input  timer_expired,
        input  time_left,
        input  time_tens,
        input  time_ones,
        input  time_warning
    );

    modport slave (
        input  game_active,
        output timer_expired,
        output time_left,
        output time_tens,
        output time_ones,
        output time_warning
    );
endinterface

// File: rtl/game_countdown_timer.sv
// Per-round countdown timer: counts 1Hz ticks down from GAME_SECONDS,
// keeping a binary and a BCD copy of the remaining time in lockstep.
module game_countdown_timer #(
    parameter int GAME_SECONDS = 30,
    parameter int WARN_SECONDS = 5
) (
    input  logic                  clkIn,
    input  logic                  reset,
    input  logic                  incrementClk,
    game_countdown_timer_if.slave tmr
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] LP_GAME    = 7'(GAME_SECONDS);
    localparam logic [3:0] LP_TENS    = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] LP_ONES    = 4'(GAME_SECONDS % 10);
    localparam logic [6:0] LP_WARN    = 7'(WARN_SECONDS);
    localparam logic       LP_WARN_EN = (WARN_SECONDS != 0);

    state_t     r_state;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [6:0] r_time;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_expired;
    logic       r_warn;

    state_t     w_state_nx;
    logic [6:0] w_time_nx;
    logic [3:0] w_tens_nx;
    logic [3:0] w_ones_nx;
    logic       w_expired_nx;
    logic       w_warn_nx;
    logic       w_tick;

    assign w_tick = r_s2 & ~r_s3;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= incrementClk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            r_state   <= IDLE;
            r_time    <= LP_GAME;
            r_tens    <= LP_TENS;
            r_ones    <= LP_ONES;
            r_expired <= 1'b0;
            r_warn    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_time    <= w_time_nx;
            r_tens    <= w_tens_nx;
            r_ones    <= w_ones_nx;
            r_expired <= w_expired_nx;
            r_warn    <= w_warn_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_time_nx    = r_time;
        w_tens_nx    = r_tens;
        w_ones_nx    = r_ones;
        w_expired_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (tmr.game_active) begin
                    w_state_nx = COUNT;
                    w_time_nx  = LP_GAME;
                    w_tens_nx  = LP_TENS;
                    w_ones_nx  = LP_ONES;
                end
            end
            COUNT: begin
                // Abort wins over a tick landing in the same cycle.
                if (!tmr.game_active) begin
                    w_state_nx = IDLE;
                    w_time_nx  = LP_GAME;
                    w_tens_nx  = LP_TENS;
                    w_ones_nx  = LP_ONES;
                end else if (w_tick && (r_time > 7'd1)) begin
                    w_time_nx = r_time - 7'd1;
                    if (r_ones == 4'd0) begin
                        w_ones_nx = 4'd9;
                        w_tens_nx = r_tens - 4'd1;
                    end else begin
                        w_ones_nx = r_ones - 4'd1;
                    end
                end else if (w_tick) begin
                    w_state_nx   = DONE;
                    w_time_nx    = 7'd0;
                    w_tens_nx    = 4'd0;
                    w_ones_nx    = 4'd0;
                    w_expired_nx = 1'b1;
                end
            end
            DONE: begin
                if (!tmr.game_active) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_time_nx  = LP_GAME;
                w_tens_nx  = LP_TENS;
                w_ones_nx  = LP_ONES;
            end
        endcase
        w_warn_nx = (w_state_nx == COUNT) && (w_time_nx <= LP_WARN)
                    && LP_WARN_EN;
    end

    assign tmr.timer_expired = r_expired;
    assign tmr.time_left     = r_time;
    assign tmr.time_tens     = r_tens;
    assign tmr.time_ones     = r_ones;
    assign tmr.time_warning  = r_warn;
endmodule

// File: tb/tb_game_countdown_timer.sv
// Randomised scoreboard bench for game_countdown_timer: a round-level
// model queues every expected display change, a monitor pops and compares.
module tb_game_countdown_timer;
    localparam int GS = 30;
    localparam int WS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inc = 1'b0;

    game_countdown_timer_if bus ();

    game_countdown_timer #(
        .GAME_SECONDS(GS),
        .WARN_SECONDS(WS)
    ) dut (
        .clkIn       (clk),
        .reset       (rst),
        .incrementClk(inc),
        .tmr         (bus.slave)
    );

    always #5 clk = ~clk;

    // Tuple layout: {time_left[6:0], tens[3:0], ones[3:0], warning, expired}
    logic [16:0] q[$];
    logic [16:0] m_last;
    int          m_mode;  // 0 idle, 1 counting, 2 finished
    int          m_secs;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;
    logic started = 1'b0;
    logic chk_req = 1'b0;
    logic chk_done = 1'b0;
    logic [16:0] prev = '0;
    logic [16:0] cur;
    logic [16:0] exp_t;

    function automatic logic [16:0] tup(int s, bit w, bit e);
        logic [6:0] t7;
        logic [3:0] d10;
        logic [3:0] d1;
        t7  = 7'(s);
        d10 = 4'(s / 10);
        d1  = 4'(s % 10);
        return {t7, d10, d1, w, e};
    endfunction

    function automatic void push_t(logic [16:0] t);
        if (t != m_last) begin
            q.push_back(t);
            m_last = t;
        end
    endfunction

    function automatic void push_state();
        bit w;
        w = (m_mode == 1) && (m_secs <= WS) && (WS != 0);
        push_t(tup(m_secs, w, 1'b0));
    endfunction

    function automatic void model_active(bit v);
        if (m_mode == 0 && v) begin
            m_mode = 1;
            m_secs = GS;
        end else if (m_mode == 1 && !v) begin
            m_mode = 0;
            m_secs = GS;
        end else if (m_mode == 2 && !v) begin
            m_mode = 0;
        end
        push_state();
    endfunction

    function automatic void model_tick();
        if (m_mode == 1) begin
            if (m_secs > 1) begin
                m_secs = m_secs - 1;
            end else begin
                m_secs = 0;
                m_mode = 2;
                push_t(tup(0, 1'b0, 1'b1));
            end
            push_state();
        end
    endfunction

    task automatic tick(int hold);
        @(posedge clk);
        #1 inc = 1'b1;
        model_tick();
        repeat (hold) @(posedge clk);
        #1 inc = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic set_active(bit v);
        @(posedge clk);
        #1 bus.game_active = v;
        model_active(v);
        repeat (3) @(posedge clk);
    endtask

    // Raw edge at P0 is acted on at P3; changing game_active after P2
    // makes the round change coincide with that tick.
    task automatic coin(bit v);
        @(posedge clk);
        #1 inc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (v != bus.game_active) model_active(v);
        else model_tick();
        bus.game_active = v;
        repeat (6) @(posedge clk);
        #1 inc = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic reset_on_tick();
        @(posedge clk);
        #1 inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.game_active = 1'b0;
        m_mode = 0;
        m_secs = GS;
        push_state();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 inc = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {bus.time_left, bus.time_tens, bus.time_ones,
                   bus.time_warning, bus.timer_expired};
            if (!started) begin
                started = 1'b1;
                total++;
                if (cur != tup(GS, 1'b0, 1'b0)) begin
                    bad++;
                    $display("FAIL reset_state got=%h want=%h",
                             cur, tup(GS, 1'b0, 1'b0));
                end
            end else begin
                if (cur != prev) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_change t=%0t got=%h want=none",
                                 $time, cur);
                    end else begin
                        exp_t = q.pop_front();
                        if (cur != exp_t) begin
                            bad++;
                            $display("FAIL event t=%0t got=%h want=%h",
                                     $time, cur, exp_t);
                        end
                    end
                end
                if (cur[0]) begin
                    total++;
                    if (prev[0]) begin
                        bad++;
                        $display("FAIL expired_width t=%0t got=2+cycles want=1",
                                 $time);
                    end
                end
            end
            total++;
            if ((32'(bus.time_tens) * 10 + 32'(bus.time_ones)
                 != 32'(bus.time_left)) || (32'(bus.time_left) > GS)) begin
                bad++;
                $display("FAIL bcd_range t=%0t got=%0d/%0d/%0d want=consistent",
                         $time, bus.time_left, bus.time_tens, bus.time_ones);
            end
            prev = cur;
        end
        if (chk_req && !chk_done) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL pending got=%0d want=0", q.size());
            end
            chk_done = 1'b1;
        end
    end

    initial begin
        int op;
        bus.game_active = 1'b0;
        m_mode = 0;
        m_secs = GS;
        m_last = tup(GS, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Full round, then ticks ignored in IDLE and DONE
        set_active(1'b1);
        for (int i = 0; i < GS; i++) tick(6);
        set_active(1'b0);
        for (int i = 0; i < 3; i++) tick(6);
        set_active(1'b1);
        for (int i = 0; i < GS; i++) tick(6);
        for (int i = 0; i < 3; i++) tick(6);
        set_active(1'b0);

        // Abort at 17 and restart
        set_active(1'b1);
        for (int i = 0; i < 13; i++) tick(6);
        set_active(1'b0);
        set_active(1'b1);
        for (int i = 0; i < 2; i++) tick(6);

        // Reset coincident with a tick at 12
        for (int i = 0; i < 16; i++) tick(6);
        reset_on_tick();

        // Held level, then an edge coincident with the load
        set_active(1'b1);
        tick(1000);
        set_active(1'b0);
        coin(1'b1);
        tick(6);
        coin(1'b0);

        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) tick(int'($urandom_range(1, 12)));
            else if (op <= 7) set_active($urandom_range(0, 3) != 0);
            else if (op == 8) coin($urandom_range(0, 3) != 0);
            else repeat (int'($urandom_range(1, 20))) @(posedge clk);
        end

        repeat (20) @(posedge clk);
        chk_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!chk_done) begin
            bad++;
            $display("FAIL final_check got=not_run want=run");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
